// File: rtl/alu16_nibble_seq_if.sv
// alu16_nibble_seq_if: request/result bus between a requester and the nibble-serial ALU
interface alu16_nibble_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin_;
    logic        busy;
    logic        done;
    logic [15:0] f;
    logic        cout_;
    logic        aeqb;
    logic        zero;
    modport master (output start, a, b, s, m, cin_, input busy, done, f, cout_, aeqb, zero);
    modport slave  (input start, a, b, s, m, cin_, output busy, done, f, cout_, aeqb, zero);
endinterface

// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq: 16-bit ALU op run through one '181 a nibble per clock, carry rippled in a flop
module sn74ls181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn_,
    output logic [3:0] f,
    output logic       cn4_,
    output logic       aeqb
);
    logic [3:0] p, g, h;
    logic [4:0] c;
    always_comb begin
        p    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        g    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        h    = p ^ g;
        c[0] = ~cn_;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & c[1]);
        c[3] = g[2] | (p[2] & c[2]);
        c[4] = g[3] | (p[3] & c[3]);
        // logic mode masks the internal carries off the sum bits
        f    = ~h ^ ({4{~m}} & ~c[3:0]);
        cn4_ = ~c[4];
        aeqb = &f;
    end
endmodule

module alu16_nibble_seq (
    input logic                    clk,
    input logic                    rst_,
    alu16_nibble_seq_if.slave      bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]  state;
    logic [1:0]  idx;
    logic [15:0] ar, br, fr;
    logic [3:0]  sr, nf;
    logic        mr, cy, eq, nc, ne;
    sn74ls181 u_alu (
        .a    (ar[{idx, 2'b00} +: 4]),
        .b    (br[{idx, 2'b00} +: 4]),
        .s    (sr),
        .m    (mr),
        .cn_  (cy),
        .f    (nf),
        .cn4_ (nc),
        .aeqb (ne)
    );
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            idx   <= 2'd0;
            ar    <= 16'h0000;
            br    <= 16'h0000;
            sr    <= 4'h0;
            mr    <= 1'b0;
            cy    <= 1'b1;
            fr    <= 16'h0000;
            eq    <= 1'b0;
        end else if (state == RUN) begin
            fr[{idx, 2'b00} +: 4] <= nf;
            cy    <= nc;
            eq    <= eq & ne;
            idx   <= idx + 2'd1;
            state <= (idx == 2'd3) ? DONE : RUN;
        end else if (bus.start) begin
            ar    <= bus.a;
            br    <= bus.b;
            sr    <= bus.s;
            mr    <= bus.m;
            cy    <= bus.cin_;
            idx   <= 2'd0;
            eq    <= 1'b1;
            state <= RUN;
        end else begin
            state <= IDLE;
        end
    end
    assign bus.busy  = state == RUN;
    assign bus.done  = state == DONE;
    assign bus.f     = fr;
    assign bus.cout_ = cy;
    assign bus.aeqb  = eq;
    assign bus.zero  = fr == 16'h0000;
endmodule

// File: tb/tb_alu16_nibble_seq.sv
// tb_alu16_nibble_seq: directed and random ops checked against the '181 function table
module tb_alu16_nibble_seq;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    alu16_nibble_seq_if bus ();
    alu16_nibble_seq dut (.clk(clk), .rst_(rst_), .bus(bus));
    always #5 clk = ~clk;

    // returns {cout_, f} from the datasheet table: arithmetic is x plus y plus carry
    function automatic logic [16:0] model(input logic [15:0] a, b, input logic [3:0] s,
                                          input logic m, cin_);
        logic [15:0] x, y, lf;
        logic [16:0] sum;
        case (s)
            4'd0:  begin x = a;      y = 16'h0;    lf = ~a;      end
            4'd1:  begin x = a | b;  y = 16'h0;    lf = ~(a | b); end
            4'd2:  begin x = a | ~b; y = 16'h0;    lf = ~a & b;  end
            4'd3:  begin x = 16'hFFFF; y = 16'h0;  lf = 16'h0;   end
            4'd4:  begin x = a;      y = a & ~b;   lf = ~(a & b); end
            4'd5:  begin x = a | b;  y = a & ~b;   lf = ~b;      end
            4'd6:  begin x = a;      y = ~b;       lf = a ^ b;   end
            4'd7:  begin x = a & ~b; y = 16'hFFFF; lf = a & ~b;  end
            4'd8:  begin x = a;      y = a & b;    lf = ~a | b;  end
            4'd9:  begin x = a;      y = b;        lf = ~(a ^ b); end
            4'd10: begin x = a | ~b; y = a & b;    lf = b;       end
            4'd11: begin x = a & b;  y = 16'hFFFF; lf = a & b;   end
            4'd12: begin x = a;      y = a;        lf = 16'hFFFF; end
            4'd13: begin x = a | b;  y = a;        lf = a | ~b;  end
            4'd14: begin x = a | ~b; y = a;        lf = a | b;   end
            default: begin x = a;    y = 16'hFFFF; lf = a;       end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cin_};
        return {~sum[16], m ? lf : sum[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] a, b, input logic [3:0] s,
                         input logic m, cin_);
        bus.start = st;
        bus.a = a;
        bus.b = b;
        bus.s = s;
        bus.m = m;
        bus.cin_ = cin_;
    endtask

    // one operation; poke drives a one-cycle start with other operands mid-RUN
    task automatic op(input logic [15:0] a, b, input logic [3:0] s, input logic m, cin_,
                      input logic poke);
        logic [16:0] e;
        int cyc, bc;
        e = model(a, b, s, m, cin_);
        @(negedge clk);
        drive(1'b1, a, b, s, m, cin_);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        bc = 0;
        while (!bus.done && cyc < 10) begin
            if (bus.busy) bc++;
            if (poke && cyc == 2) drive(1'b1, ~a, a ^ b, ~s, ~m, ~cin_);
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk("latency", cyc, 5);
        chk("busy_cycles", bc, 4);
        chk("f", {16'h0, bus.f}, {16'h0, e[15:0]});
        chk("cout_", {31'h0, bus.cout_}, {31'h0, e[16]});
        chk("aeqb", {31'h0, bus.aeqb}, {31'h0, e[15:0] == 16'hFFFF});
        chk("zero", {31'h0, bus.zero}, {31'h0, e[15:0] == 16'h0000});
        @(negedge clk);
        chk("done_pulse", {31'h0, bus.done}, 32'h0);
    endtask

    initial begin
        logic [16:0] e;
        int nd, d1, d2, w;
        drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_f", {16'h0, bus.f}, 32'h0);
        chk("rst_cout_", {31'h0, bus.cout_}, 32'h1);
        chk("rst_aeqb", {31'h0, bus.aeqb}, 32'h0);
        chk("rst_zero", {31'h0, bus.zero}, 32'h1);
        rst_ = 1'b1;
        op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
        chk("add_const", {16'h0, bus.f}, 32'h2233);
        op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
        chk("carry_const", {15'h0, bus.cout_, bus.f}, 32'h0);
        op(16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("sub_const", {15'h0, bus.cout_, bus.f}, 32'h0002);
        op(16'h4321, 16'h4321, 4'b0110, 1'b0, 1'b1, 1'b0);
        chk("cmp_const", {15'h0, bus.aeqb, bus.f}, 32'h1FFFF);
        op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0);
        chk("xor_const", {16'h0, bus.f}, 32'h0FF0);
        for (int i = 0; i < 24; i++)
            op(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        op(16'hA5C3, 16'h1F2E, 4'b1001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            op(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        // start held high: back-to-back operations every five edges
        e = model(16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b1);
        nd = 0;
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (nd == 0) d1 = i;
                else if (nd == 1) d2 = i;
                nd++;
                chk("hold_f", {15'h0, bus.cout_, bus.f}, {15'h0, e});
            end
        end
        bus.start = 1'b0;
        chk("hold_first", d1, 5);
        chk("hold_gap", d2 - d1, 5);
        w = 0;
        while (!bus.done && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("hold_drain", {31'h0, bus.done}, 32'h1);
        @(negedge clk);
        // reset two edges into RUN
        @(negedge clk);
        drive(1'b1, 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        chk("abort_f", {16'h0, bus.f}, 32'h0);
        chk("abort_cout_", {31'h0, bus.cout_}, 32'h1);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk("post_rst_done", {30'h0, bus.busy, bus.done}, 32'h0);
        op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
        chk("post_rst_add", {16'h0, bus.f}, 32'h0002);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
